// File: rtl/t03_vtg_pkg.sv
`default_nettype none
// ============================================================================
// Module      : t03_vtg_pkg
// Description : Shared types and helpers for the t03 video timing generator.
//               vtg_region_e names the four regions of one raster axis in
//               scan order. region_of() classifies a counter value against
//               the active / front-porch / sync widths of that axis.
// Revision    : 1.0 - initial release
// ============================================================================
package t03_vtg_pkg;

   // Scan order along either axis: visible pixels, front porch, sync pulse,
   // back porch. Anything past the sync window (including out-of-range
   // counts) classifies as BACK, so it never asserts sync or active.
   typedef enum logic [1:0] {
      ACTIVE = 2'd0,
      FRONT  = 2'd1,
      SYNC   = 2'd2,
      BACK   = 2'd3
   } vtg_region_e;

   // Arguments are zero-extended to 32 bits by the caller, so the region
   // boundaries are plain unsigned compares.
   function automatic vtg_region_e region_of(
      input logic [31:0] cnt,
      input logic [31:0] act,
      input logic [31:0] fp,
      input logic [31:0] sync
   );
      logic [31:0] w_fp_end;
      logic [31:0] w_sync_end;
      vtg_region_e w_region;
      w_fp_end   = act + fp;
      w_sync_end = w_fp_end + sync;
      if (cnt < act) begin
         w_region = ACTIVE;
      end else if (cnt < w_fp_end) begin
         w_region = FRONT;
      end else if (cnt < w_sync_end) begin
         w_region = SYNC;
      end else begin
         w_region = BACK;
      end
      return w_region;
   endfunction

endpackage : t03_vtg_pkg
`default_nettype wire

// File: rtl/t03_vtg_axis_counter.sv
`default_nettype none
// ============================================================================
// Module      : t03_vtg_axis_counter
// Description : One raster axis counter. Counts 0..TOTAL-1 on each step and
//               wraps to 0. A count above TOTAL-1 (only reachable through a
//               state upset) is forced back to 0 on the next clock whether
//               or not step is high.
// Ports       : clk   in   system clock
//               rst   in   synchronous active-high reset
//               step  in   advance request for this axis
//               cnt   out  [CNT_W-1:0] current count
//               tc    out  step && cnt==TOTAL-1 (terminal count this clock)
// Revision    : 1.0 - initial release
// ============================================================================
module t03_vtg_axis_counter #(
   parameter int CNT_W = 11,
   parameter int TOTAL = 1040
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             step,
   output logic [CNT_W-1:0] cnt,
   output logic             tc
);

   localparam logic [CNT_W-1:0] c_LAST = CNT_W'(TOTAL - 1);

   logic [CNT_W-1:0] r_cnt;
   logic             w_at_last;
   logic             w_out_of_range;

   assign w_at_last      = (r_cnt == c_LAST);
   // Comparing against the last legal value rather than TOTAL keeps this
   // correct even when TOTAL equals 2**CNT_W.
   assign w_out_of_range = (r_cnt > c_LAST);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_cnt <= '0;
      end else if (w_out_of_range) begin
         r_cnt <= '0;
      end else if (step) begin
         r_cnt <= w_at_last ? '0 : r_cnt + 1'b1;
      end
   end

   assign cnt = r_cnt;
   assign tc  = step && w_at_last;

endmodule : t03_vtg_axis_counter
`default_nettype wire

// File: rtl/t03_video_timing_gen.sv
`default_nettype none
// ============================================================================
// Module      : t03_video_timing_gen
// Description : Parametrised raster timing generator. A horizontal counter
//               steps on en, a vertical counter steps on the horizontal
//               line-end strobe. Sync, blank and strobe outputs decode
//               combinationally from the counters and en with no latency.
//               Out-of-range counters recover to 0 on the next clock and
//               suppress all strobes while out of range.
// Build option: define T03_VTG_FRAME_CNT_EN to add the frame_cnt output and
//               its completed-frame counter (FRAME_W bits, wraps).
// Ports       : clk          in   system clock
//               rst          in   synchronous active-high reset
//               en           in   pixel enable
//               hcnt         out  [CNT_W-1:0] pixel column
//               vcnt         out  [CNT_W-1:0] line
//               hsync        out  horizontal sync, level HSYNC_POL in sync
//               vsync        out  vertical sync, level VSYNC_POL in sync
//               active       out  visible-area flag
//               h_tc         out  line-end strobe
//               line_start   out  line-start strobe
//               frame_start  out  frame-start strobe
//               frame_cnt    out  [FRAME_W-1:0] completed frames (option)
// Revision    : 1.0 - initial release
// ============================================================================
module t03_video_timing_gen
   import t03_vtg_pkg::*;
#(
   parameter int CNT_W     = 11,
   parameter int H_ACTIVE  = 800,
   parameter int H_FP      = 56,
   parameter int H_SYNC    = 120,
   parameter int H_BP      = 64,
   parameter int V_ACTIVE  = 600,
   parameter int V_FP      = 37,
   parameter int V_SYNC    = 6,
   parameter int V_BP      = 23,
   parameter bit HSYNC_POL = 1'b1,
   parameter bit VSYNC_POL = 1'b1,
   parameter int FRAME_W   = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               en,
   output logic [CNT_W-1:0]   hcnt,
   output logic [CNT_W-1:0]   vcnt,
   output logic               hsync,
   output logic               vsync,
   output logic               active,
   output logic               h_tc,
   output logic               line_start,
   output logic               frame_start
`ifdef T03_VTG_FRAME_CNT_EN
   ,
   output logic [FRAME_W-1:0] frame_cnt
`endif
);

   // ------------------------------------------------------------------
   // Geometry constants
   // ------------------------------------------------------------------
   localparam int c_H_TOTAL   = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int c_V_TOTAL   = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int c_MAX_TOTAL = (c_H_TOTAL > c_V_TOTAL) ? c_H_TOTAL : c_V_TOTAL;

   localparam logic [CNT_W-1:0] c_H_ACT  = CNT_W'(H_ACTIVE);
   localparam logic [CNT_W-1:0] c_H_FP   = CNT_W'(H_FP);
   localparam logic [CNT_W-1:0] c_H_SYN  = CNT_W'(H_SYNC);
   localparam logic [CNT_W-1:0] c_H_LAST = CNT_W'(c_H_TOTAL - 1);
   localparam logic [CNT_W-1:0] c_V_ACT  = CNT_W'(V_ACTIVE);
   localparam logic [CNT_W-1:0] c_V_FP   = CNT_W'(V_FP);
   localparam logic [CNT_W-1:0] c_V_SYN  = CNT_W'(V_SYNC);
   localparam logic [CNT_W-1:0] c_V_LAST = CNT_W'(c_V_TOTAL - 1);

   // ------------------------------------------------------------------
   // Elaboration-time parameter checks
   // ------------------------------------------------------------------
   if ((H_ACTIVE < 1) || (H_FP < 1) || (H_SYNC < 1) || (H_BP < 1) ||
       (V_ACTIVE < 1) || (V_FP < 1) || (V_SYNC < 1) || (V_BP < 1)) begin : g_chk_timing
      $error("t03_video_timing_gen: every timing parameter must be >= 1");
   end

   if ((64'd1 << CNT_W) < 64'(c_MAX_TOTAL)) begin : g_chk_width
      $error("t03_video_timing_gen: CNT_W too narrow for H_TOTAL/V_TOTAL");
   end

   // ------------------------------------------------------------------
   // Axis counters
   // ------------------------------------------------------------------
   logic [CNT_W-1:0] w_hcnt;
   logic [CNT_W-1:0] w_vcnt;
   logic             w_h_wrap;
   logic             w_v_wrap;
   logic             w_h_tc;
   logic             w_h_in;
   logic             w_v_in;
   logic             w_both_in;

   assign w_h_in    = (w_hcnt <= c_H_LAST);
   assign w_v_in    = (w_vcnt <= c_V_LAST);
   assign w_both_in = w_h_in && w_v_in;

   t03_vtg_axis_counter #(
      .CNT_W (CNT_W),
      .TOTAL (c_H_TOTAL)
   ) u_h (
      .clk  (clk),
      .rst  (rst),
      .step (en),
      .cnt  (w_hcnt),
      .tc   (w_h_wrap)
   );

   // The raw wrap already implies hcnt is in range; gating with the
   // vertical range keeps the line-end strobe quiet while vcnt recovers.
   assign w_h_tc = w_h_wrap && w_v_in;

   t03_vtg_axis_counter #(
      .CNT_W (CNT_W),
      .TOTAL (c_V_TOTAL)
   ) u_v (
      .clk  (clk),
      .rst  (rst),
      .step (w_h_tc),
      .cnt  (w_vcnt),
      .tc   (w_v_wrap)
   );

   // ------------------------------------------------------------------
   // Region decode
   // ------------------------------------------------------------------
   vtg_region_e w_h_region;
   vtg_region_e w_v_region;

   assign w_h_region = region_of(32'(w_hcnt), 32'(c_H_ACT), 32'(c_H_FP), 32'(c_H_SYN));
   assign w_v_region = region_of(32'(w_vcnt), 32'(c_V_ACT), 32'(c_V_FP), 32'(c_V_SYN));

   // vsync needs no special alignment: vcnt itself only moves on the clock
   // where hcnt wraps to 0, so the decode follows the line boundary.
   assign hsync  = (w_h_region == SYNC) ? HSYNC_POL : ~HSYNC_POL;
   assign vsync  = (w_v_region == SYNC) ? VSYNC_POL : ~VSYNC_POL;
   assign active = (w_h_region == ACTIVE) && (w_v_region == ACTIVE);

   assign hcnt        = w_hcnt;
   assign vcnt        = w_vcnt;
   assign h_tc        = w_h_tc;
   assign line_start  = en && w_both_in && (w_hcnt == '0);
   assign frame_start = en && w_both_in && (w_hcnt == '0) && (w_vcnt == '0);

   // ------------------------------------------------------------------
   // Completed-frame counter (build option)
   // ------------------------------------------------------------------
`ifdef T03_VTG_FRAME_CNT_EN
   logic [FRAME_W-1:0] r_frame_cnt;

   // w_v_wrap is h_tc on the last line: the clock where vcnt returns to 0.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_frame_cnt <= '0;
      end else if (w_v_wrap) begin
         r_frame_cnt <= r_frame_cnt + 1'b1;
      end
   end

   assign frame_cnt = r_frame_cnt;
`else
   // Without the frame counter the vertical terminal count and FRAME_W
   // have no consumer.
   localparam int c_unused_FRAME_W = FRAME_W;
   logic w_unused_v_wrap;
   assign w_unused_v_wrap = w_v_wrap;
`endif

endmodule : t03_video_timing_gen
`default_nettype wire

// File: tb/tb_t03_video_timing_gen.sv
`default_nettype none
// ============================================================================
// Module      : tb_t03_video_timing_gen
// Description : Self-checking bench for t03_video_timing_gen. Two instances
//               share clk/rst/en: index 0 uses the default 800x600 geometry,
//               index 1 a compact 28x17 raster with active-low syncs so that
//               whole frames are short. A linear-position model predicts
//               every output on every cycle; literal checks pin the model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_t03_video_timing_gen;

   localparam int CW = 11;
   localparam int S_HA = 16, S_HF = 3, S_HS = 5, S_HB = 4;
   localparam int S_VA = 10, S_VF = 2, S_VS = 3, S_VB = 2;
   localparam int S_FRAME = (S_HA + S_HF + S_HS + S_HB) * (S_VA + S_VF + S_VS + S_VB);

   // per-instance geometry used by the model
   int ha  [2] = '{800, S_HA};
   int hf  [2] = '{56,  S_HF};
   int hsw [2] = '{120, S_HS};
   int hb  [2] = '{64,  S_HB};
   int va  [2] = '{600, S_VA};
   int vf  [2] = '{37,  S_VF};
   int vsw [2] = '{6,   S_VS};
   int vb  [2] = '{23,  S_VB};
   bit hp  [2] = '{1'b1, 1'b0};
   bit vp  [2] = '{1'b1, 1'b0};
   int fmod[2] = '{256, 4};
   int ht  [2];
   int vt  [2];

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic en  = 1'b1;

   logic [CW-1:0] b_h, b_v, s_h, s_v;
   logic b_hs, b_vs, b_act, b_tc, b_ls, b_fs;
   logic s_hs, s_vs, s_act, s_tc, s_ls, s_fs;
   logic [7:0] b_fcx, s_fcx;
`ifdef T03_VTG_FRAME_CNT_EN
   logic [7:0] b_fc;
   logic [1:0] s_fc;
   assign b_fcx = b_fc;
   assign s_fcx = {6'd0, s_fc};
`else
   assign b_fcx = 8'd0;
   assign s_fcx = 8'd0;
`endif

   always #5 clk = ~clk;

   t03_video_timing_gen u_big (
      .clk         (clk),
      .rst         (rst),
      .en          (en),
      .hcnt        (b_h),
      .vcnt        (b_v),
      .hsync       (b_hs),
      .vsync       (b_vs),
      .active      (b_act),
      .h_tc        (b_tc),
      .line_start  (b_ls),
      .frame_start (b_fs)
`ifdef T03_VTG_FRAME_CNT_EN
      ,
      .frame_cnt   (b_fc)
`endif
   );

   t03_video_timing_gen #(
      .CNT_W (CW),
      .H_ACTIVE (S_HA), .H_FP (S_HF), .H_SYNC (S_HS), .H_BP (S_HB),
      .V_ACTIVE (S_VA), .V_FP (S_VF), .V_SYNC (S_VS), .V_BP (S_VB),
      .HSYNC_POL (1'b0), .VSYNC_POL (1'b0), .FRAME_W (2)
   ) u_small (
      .clk         (clk),
      .rst         (rst),
      .en          (en),
      .hcnt        (s_h),
      .vcnt        (s_v),
      .hsync       (s_hs),
      .vsync       (s_vs),
      .active      (s_act),
      .h_tc        (s_tc),
      .line_start  (s_ls),
      .frame_start (s_fs)
`ifdef T03_VTG_FRAME_CNT_EN
      ,
      .frame_cnt   (s_fc)
`endif
   );

   // ------------------------------------------------------------------
   // Model: raster position per instance
   // ------------------------------------------------------------------
   int mh[2], mv[2], mf[2];
   int n_chk = 0;
   int n_err = 0;
   bit chk_on = 1'b0;
   int fs_seen[2], hs_seen[2], vs_seen[2], act_seen[2];

   // A legal position advances as one linear pixel index around the frame;
   // an illegal coordinate simply snaps to 0.
   task automatic model_step();
      for (int k = 0; k < 2; k++) begin
         if (rst) begin
            mh[k] = 0; mv[k] = 0; mf[k] = 0;
         end else if (mh[k] < ht[k] && mv[k] < vt[k]) begin
            if (en) begin
               int p;
               p = (mv[k] * ht[k] + mh[k] + 1) % (ht[k] * vt[k]);
               if (p == 0) mf[k] = (mf[k] + 1) % fmod[k];
               mh[k] = p % ht[k];
               mv[k] = p / ht[k];
            end
         end else begin
            if (mh[k] >= ht[k]) mh[k] = 0;
            else if (en) mh[k] = (mh[k] + 1) % ht[k];
            if (mv[k] >= vt[k]) mv[k] = 0;
         end
      end
   endtask

   // {h[11], v[11], hsync, vsync, active, h_tc, line_start, frame_start, fc[8]}
   function automatic logic [35:0] model_out(int k);
      int h, v, hs0, vs0;
      bit ok, e_hs, e_vs, e_act, e_tc, e_ls, e_fs;
      logic [10:0] h11, v11;
      logic [7:0] f8;
      h = mh[k]; v = mv[k];
      ok = (h < ht[k]) && (v < vt[k]);
      hs0 = ha[k] + hf[k];
      vs0 = va[k] + vf[k];
      e_hs = (h >= hs0 && h < hs0 + hsw[k]) ? hp[k] : !hp[k];
      e_vs = (v >= vs0 && v < vs0 + vsw[k]) ? vp[k] : !vp[k];
      e_act = (h < ha[k]) && (v < va[k]);
      e_tc = en && ok && (h == ht[k] - 1);
      e_ls = en && ok && (h == 0);
      e_fs = e_ls && (v == 0);
      h11 = h[10:0];
      v11 = v[10:0];
`ifdef T03_VTG_FRAME_CNT_EN
      f8 = mf[k][7:0];
`else
      f8 = 8'd0;
`endif
      return {h11, v11, e_hs, e_vs, e_act, e_tc, e_ls, e_fs, f8};
   endfunction

   // ------------------------------------------------------------------
   // Per-cycle compare (falling edge, away from the active edge)
   // ------------------------------------------------------------------
   logic [35:0] cg, ce;
   always @(negedge clk) begin
      if (chk_on) begin
         for (int k = 0; k < 2; k++) begin
            ce = model_out(k);
            if (k == 0) cg = {b_h, b_v, b_hs, b_vs, b_act, b_tc, b_ls, b_fs, b_fcx};
            else        cg = {s_h, s_v, s_hs, s_vs, s_act, s_tc, s_ls, s_fs, s_fcx};
            n_chk++;
            if (cg !== ce) begin
               n_err++;
               $display("FAIL cycle_cmp dut%0d t=%0t got h=%0d v=%0d hs/vs/act/tc/ls/fs=%b fc=%0d required h=%0d v=%0d hs/vs/act/tc/ls/fs=%b fc=%0d",
                        k, $time, cg[35:25], cg[24:14], cg[13:8], cg[7:0],
                        ce[35:25], ce[24:14], ce[13:8], ce[7:0]);
            end
            if (cg[8] === 1'b1)   fs_seen[k]++;
            if (cg[13] === hp[k]) hs_seen[k]++;
            if (cg[12] === vp[k]) vs_seen[k]++;
            if (cg[11] === 1'b1)  act_seen[k]++;
         end
      end
   end

   // ------------------------------------------------------------------
   // Stimulus helpers
   // ------------------------------------------------------------------
   task automatic expect_eq(string name, int got, int want);
      n_chk++;
      if (got != want) begin
         n_err++;
         $display("FAIL %s got %0d required %0d", name, got, want);
      end
   endtask

   // Advance one clock, then apply the inputs for the following cycle.
   task automatic step(bit r, bit e);
      @(posedge clk);
      model_step();
      #1;
      rst = r;
      en  = e;
   endtask

   task automatic run(int n, bit e);
      repeat (n) step(1'b0, e);
   endtask

   task automatic peek();
      @(negedge clk);
   endtask

   int fs0, hs0, vs0, act0, ntc, nls;
   int fexp[5] = '{1, 2, 3, 0, 1};

   initial begin
      for (int k = 0; k < 2; k++) begin
         ht[k] = ha[k] + hf[k] + hsw[k] + hb[k];
         vt[k] = va[k] + vf[k] + vsw[k] + vb[k];
         mh[k] = 0; mv[k] = 0; mf[k] = 0;
         fs_seen[k] = 0; hs_seen[k] = 0; vs_seen[k] = 0; act_seen[k] = 0;
      end

      // reset for two clocks, en held high
      step(1'b1, 1'b1);
      chk_on = 1'b1;
      step(1'b0, 1'b1);
      peek();
      expect_eq("rst_hcnt", b_h, 0);
      expect_eq("rst_vcnt", b_v, 0);
      expect_eq("rst_active", b_act, 1);
      expect_eq("rst_hsync", b_hs, 0);
      expect_eq("rst_vsync", b_vs, 0);
      expect_eq("rst_frame_start", b_fs, 1);
      expect_eq("rst_small_hsync_idle", s_hs, 1);
      expect_eq("rst_small_vsync_idle", s_vs, 1);

      // first line of the default raster
      run(799, 1'b1); peek();
      expect_eq("h799_active", b_act, 1);
      expect_eq("model_h799", mh[0], 799);
      run(1, 1'b1); peek();
      expect_eq("h800_active", b_act, 0);
      run(55, 1'b1); peek();
      expect_eq("h855_hsync", b_hs, 0);
      run(1, 1'b1); peek();
      expect_eq("h856_hsync", b_hs, 1);
      expect_eq("model_h856", mh[0], 856);
      run(119, 1'b1); peek();
      expect_eq("h975_hsync", b_hs, 1);
      run(1, 1'b1); peek();
      expect_eq("h976_hsync", b_hs, 0);
      run(63, 1'b1); peek();
      expect_eq("h1039_h_tc", b_tc, 1);
      expect_eq("h1039_vcnt", b_v, 0);
      run(1, 1'b1); peek();
      expect_eq("wrap_hcnt", b_h, 0);
      expect_eq("wrap_vcnt", b_v, 1);
      expect_eq("wrap_line_start", b_ls, 1);
      expect_eq("wrap_frame_start", b_fs, 0);

      // exactly one compact frame: region and strobe totals
      fs0 = fs_seen[1]; hs0 = hs_seen[1]; vs0 = vs_seen[1]; act0 = act_seen[1];
      run(S_FRAME, 1'b1);
      expect_eq("small_frame_starts", fs_seen[1] - fs0, 1);
      expect_eq("small_hsync_cycles", hs_seen[1] - hs0, 5 * 17);
      expect_eq("small_vsync_cycles", vs_seen[1] - vs0, 3 * 28);
      expect_eq("small_active_cycles", act_seen[1] - act0, 16 * 10);

      // en toggled 1-in-3 across the line end of the default raster
      run(1037 - S_FRAME, 1'b1);
      peek();
      expect_eq("gate_start_h", b_h, 1037);
      ntc = 0; nls = 0;
      for (int i = 0; i < 12; i++) begin
         if (i > 0) peek();
         ntc += int'(b_tc);
         nls += int'(b_ls);
         step(1'b0, ((i + 1) % 3) == 0);
      end
      peek();
      expect_eq("gate_h_tc_pulses", ntc, 1);
      expect_eq("gate_line_starts", nls, 1);
      expect_eq("gate_end_h", b_h, 1);
      expect_eq("gate_end_v", b_v, 2);

      // randomized enable with sparse resets
      for (int i = 0; i < 3000; i++) begin
         step($urandom_range(0, 199) == 0, $urandom_range(0, 3) != 0);
      end

      // reset in mid-frame
      step(1'b0, 1'b0);
      u_big.u_h.r_cnt = 11'd400;
      u_big.u_v.r_cnt = 11'd300;
      mh[0] = 400; mv[0] = 300;
      peek();
      expect_eq("midframe_h", b_h, 400);
      step(1'b1, 1'b1);
      step(1'b0, 1'b1);
      peek();
      expect_eq("midrst_h", b_h, 0);
      expect_eq("midrst_v", b_v, 0);
`ifdef T03_VTG_FRAME_CNT_EN
      expect_eq("midrst_frame_cnt", b_fc, 0);
`endif

      // out-of-range column with en low
      step(1'b0, 1'b0);
      u_big.u_h.r_cnt = 11'd1500;
      mh[0] = 1500;
      peek();
      expect_eq("oor_h", b_h, 1500);
      expect_eq("oor_h_tc", b_tc, 0);
      expect_eq("oor_line_start", b_ls, 0);
      expect_eq("oor_frame_start", b_fs, 0);
      expect_eq("oor_hsync", b_hs, 0);
      step(1'b0, 1'b1);
      u_big.u_v.r_cnt = 11'd700;
      mv[0] = 700;
      peek();
      expect_eq("recover_h", b_h, 0);
      expect_eq("oor_v_line_start", b_ls, 0);
      step(1'b0, 1'b1);
      peek();
      expect_eq("recover_v", b_v, 0);
      expect_eq("recover_v_h", b_h, 1);

`ifdef T03_VTG_FRAME_CNT_EN
      // compact raster, 2-bit frame counter over five frames
      step(1'b1, 1'b1);
      step(1'b0, 1'b1);
      for (int f = 0; f < 5; f++) begin
         run(S_FRAME - 1, 1'b1);
         peek();
         expect_eq("fc_before_wrap", s_fc, (f == 0) ? 0 : fexp[f - 1]);
         expect_eq("fc_last_line", s_v, 16);
         run(1, 1'b1);
         peek();
         expect_eq("fc_after_wrap", s_fc, fexp[f]);
         expect_eq("model_fc", mf[1], fexp[f]);
      end
`endif

      run(4, 1'b1);
      chk_on = 1'b0;
      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule : tb_t03_video_timing_gen
`default_nettype wire
